fft_spec_buf: RTL and testbench
===============================

FFT_SPEC_BUF -- requirements
Module: fft_spec_buf

Interface
REQ-001 SHALL have parameter FFT_POINT, default 256, number of bins per frame (power of two, max 1024).
REQ-002 SHALL have parameter DATA_W, default 16, width of the signed FFT real and imaginary inputs.
REQ-003 SHALL have parameter MAG_SHIFT, default 0, right shift applied to the magnitude before storage.
REQ-004 SHALL have port: pix_clk  in  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port: rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports: fft_re / fft_im  in  DATA_W each  signed FFT bin, two's complement.
REQ-007 SHALL have port: fft_valid  in  1  bin present on fft_re/fft_im.
REQ-008 SHALL have port: fft_last  in  1  marks final bin of a frame.
REQ-009 SHALL have port: fft_ready  out  1  block accepts the bin this cycle.
REQ-010 SHALL have port: data_req  in  1  display read strobe.
REQ-011 SHALL have port: RAM_address  in  10  display bin index.
REQ-012 SHALL have port: fft_data  out  32  scaled magnitude, zero-extended.
REQ-013 SHALL have ports: frame_done / frame_err  out  1 each  single-cycle status pulses.

Function
REQ-014 SHALL accept a bin only when fft_valid and fft_ready are both high; accepted bins take bin index 0..FFT_POINT-1 in order.
REQ-015 SHALL compute, over a 2-stage pipeline, a = |re|, b = |im| (unsigned, -2^(DATA_W-1) maps to 2^(DATA_W-1)), then mag = max(a,b) + (min(a,b) >> 1), then mag >> MAG_SHIFT.
REQ-016 SHALL write mag into the write bank of a two-bank buffer at the accepted bin index, 2 cycles after acceptance.
REQ-017 SHALL implement states FILL and PEND; reset enters FILL with fft_ready = 1.
REQ-018 In FILL, SHALL move to PEND once the write of bin FFT_POINT-1 with fft_last = 1 has committed; fft_ready SHALL be 0 in PEND.
REQ-019 In PEND, SHALL swap banks in the first cycle with data_req = 0, pulse frame_done, set the valid flag, reset the bin index and return to FILL.
REQ-020 SHALL NOT swap while data_req = 1, so one display line always reads a single frame.
REQ-021 SHALL treat fft_last on an index other than FFT_POINT-1, or a missing fft_last at FFT_POINT-1, as an error: pulse frame_err, discard the partial frame, reset the index to 0 and stay in FILL.
REQ-022 SHALL register fft_data 1 cycle after data_req = 1 with the read-bank value at RAM_address, and hold fft_data when data_req = 0.
REQ-023 SHALL return 0 on fft_data when RAM_address >= FFT_POINT, or when the valid flag is clear.

Reset
REQ-024 While rst is high, SHALL hold: state FILL, fft_ready 1, index 0, valid flag 0, bank select 0, fft_data 0, frame_done 0, frame_err 0, pipeline valids 0.
REQ-025 Reset mid-frame SHALL discard the partial frame and flush in-flight pipeline writes; RAM contents are not cleared.

Configuration
REQ-026 SHALL use macro FFT_SPEC_AVG_EN.
- Defined: stored value = old + ((mag - old) >>> 2), signed arithmetic, where old is the same bin in the read bank; this adds 1 pipeline stage, so the write is 3 cycles after acceptance.
- Undefined: stored value = mag, with no extra stage.

Structure
REQ-027 SHALL place FFT_POINT default, MAG_W (= DATA_W), and the state encoding (FILL, PEND) in shared package fft_spec_pkg.
REQ-028 SHALL implement the buffer as sub-module spec_dpram: two banks of FFT_POINT x 32, one write port, one registered read port, with bank-select address MSB.

Verification
REQ-029 Feed re = 3, im = -4 for all 256 bins with fft_last on bin 255, then read addr 0 -> fft_data = 5 (4 + 3>>1), and frame_done pulses once.
REQ-030 Feed re = -32768, im = 0 on bin 7 -> read addr 7 returns 32768; read addr 300 -> returns 0.
REQ-031 Complete a frame while data_req = 1 for 1280 cycles -> no swap and fft_ready = 0 until data_req falls; frame_done pulses on the first cycle with data_req = 0.
REQ-032 Assert fft_last on bin 100 -> frame_err pulses, no frame_done, the next full frame is stored correctly.
REQ-033 Assert rst at bin 50 of the 2nd frame -> after reset all reads return 0 until a new full frame swaps in.
REQ-034 With FFT_SPEC_AVG_EN defined, feed old = 0 and constant mag = 100 -> bin reads 25, 43, 57 over three frames.

Source files
------------

// File: rtl/fft_spec_pkg.sv
// ---------------------------------------------------------------------------
// Module  : fft_spec_pkg
// Brief   : Shared defaults and frame-control state encoding for fft_spec_buf
// Rev     : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

package fft_spec_pkg;

  localparam int FFT_POINT_DEF = 256;
  localparam int MAG_W         = 16;

  localparam int                STATE_W = 1;
  localparam logic [STATE_W-1:0] FILL   = 1'b0;
  localparam logic [STATE_W-1:0] PEND   = 1'b1;

endpackage

`default_nettype wire

// File: rtl/spec_dpram.sv
// ---------------------------------------------------------------------------
// Module  : spec_dpram
// Brief   : Two-bank spectrum RAM, bank select is the address MSB
// Rev     : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module spec_dpram #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          pix_clk,
  input  logic          rst,
  input  logic          i_wr_en,
  input  logic [AW:0]   i_wr_addr,
  input  logic [31:0]   i_wr_data,
  input  logic          i_rd_en,
  input  logic [AW:0]   i_rd_addr,
  output logic [31:0]   o_rd_data
`ifdef FFT_SPEC_AVG_EN
  ,
  input  logic [AW:0]   i_old_addr,
  output logic [31:0]   o_old_data
`endif
);

  logic [31:0] r_mem [2*DEPTH];

  always_ff @(posedge pix_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  // Display read port holds its last value between strobes
  always_ff @(posedge pix_clk or posedge rst) begin
    if (rst)          o_rd_data <= 32'd0;
    else if (i_rd_en) o_rd_data <= r_mem[i_rd_addr];
  end

`ifdef FFT_SPEC_AVG_EN
  always_ff @(posedge pix_clk) begin
    o_old_data <= r_mem[i_old_addr];
  end
`endif

endmodule

`default_nettype wire

// File: rtl/fft_spec_buf.sv
// ---------------------------------------------------------------------------
// Module  : fft_spec_buf
// Brief   : FFT magnitude estimator into a double-buffered display RAM.
//           Define FFT_SPEC_AVG_EN for 1/4-weight per-bin frame averaging.
// Rev     : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module fft_spec_buf
  import fft_spec_pkg::*;
#(
  parameter int FFT_POINT = FFT_POINT_DEF,
  parameter int DATA_W    = MAG_W,
  parameter int MAG_SHIFT = 0
) (
  input  logic              pix_clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] fft_re,
  input  logic [DATA_W-1:0] fft_im,
  input  logic              fft_valid,
  input  logic              fft_last,
  output logic              fft_ready,
  input  logic              data_req,
  input  logic [9:0]        RAM_address,
  output logic [31:0]       fft_data,
  output logic              frame_done,
  output logic              frame_err
);

  localparam int              c_aw       = (FFT_POINT > 1) ? $clog2(FFT_POINT) : 1;
  localparam logic [c_aw-1:0] c_last_idx = c_aw'(FFT_POINT - 1);

  logic [STATE_W-1:0] r_state;
  logic               r_hold, r_bank, r_valid_flag, r_done, r_err, r_rd_zero;
  logic [c_aw-1:0]    r_idx;

  logic               r_s1_vld, r_s1_end, r_s2_vld, r_s2_end;
  logic [c_aw-1:0]    r_s1_idx, r_s2_idx;
  logic [DATA_W-1:0]  r_s1_a, r_s1_b, r_s2_mag;

  logic               w_acc, w_at_end, w_err, w_good_end;
  logic [DATA_W-1:0]  w_abs_re, w_abs_im, w_max, w_min, w_mag;
  logic               w_wr_vld, w_wr_end;
  logic [c_aw-1:0]    w_wr_idx;
  logic [31:0]        w_wr_data, w_rd_data;
  logic [10:0]        w_addr_ext;

  assign fft_ready  = (r_state == FILL) && !r_hold;
  assign w_acc      = fft_valid && fft_ready;
  assign w_at_end   = (r_idx == c_last_idx);
  assign w_err      = w_acc && (fft_last != w_at_end);
  assign w_good_end = w_acc && fft_last && w_at_end;

  // Two's-complement abs; the most negative code wraps onto 2^(DATA_W-1) unsigned
  assign w_abs_re = fft_re[DATA_W-1] ? (~fft_re + DATA_W'(1)) : fft_re;
  assign w_abs_im = fft_im[DATA_W-1] ? (~fft_im + DATA_W'(1)) : fft_im;
  assign w_max    = (r_s1_a >= r_s1_b) ? r_s1_a : r_s1_b;
  assign w_min    = (r_s1_a >= r_s1_b) ? r_s1_b : r_s1_a;
  assign w_mag    = (w_max + (w_min >> 1)) >> MAG_SHIFT;

  always_ff @(posedge pix_clk or posedge rst) begin
    if (rst) begin
      r_s1_vld <= 1'b0;
      r_s1_end <= 1'b0;
      r_s1_idx <= '0;
      r_s1_a   <= '0;
      r_s1_b   <= '0;
      r_s2_vld <= 1'b0;
      r_s2_end <= 1'b0;
      r_s2_idx <= '0;
      r_s2_mag <= '0;
    end else begin
      r_s1_vld <= w_acc;
      r_s1_end <= w_good_end;
      r_s1_idx <= r_idx;
      r_s1_a   <= w_abs_re;
      r_s1_b   <= w_abs_im;
      r_s2_vld <= r_s1_vld;
      r_s2_end <= r_s1_end;
      r_s2_idx <= r_s1_idx;
      r_s2_mag <= w_mag;
    end
  end

`ifdef FFT_SPEC_AVG_EN
  logic               r_s3_vld, r_s3_end;
  logic [c_aw-1:0]    r_s3_idx;
  logic [31:0]        r_s3_val, w_old, w_avg;
  logic signed [33:0] w_diff;

  assign w_diff = $signed({2'b00, 32'(r_s2_mag)}) - $signed({2'b00, w_old});
  assign w_avg  = w_old + 32'(w_diff >>> 2);

  always_ff @(posedge pix_clk or posedge rst) begin
    if (rst) begin
      r_s3_vld <= 1'b0;
      r_s3_end <= 1'b0;
      r_s3_idx <= '0;
      r_s3_val <= 32'd0;
    end else begin
      r_s3_vld <= r_s2_vld;
      r_s3_end <= r_s2_end;
      r_s3_idx <= r_s2_idx;
      r_s3_val <= w_avg;
    end
  end

  assign w_wr_vld  = r_s3_vld;
  assign w_wr_end  = r_s3_end;
  assign w_wr_idx  = r_s3_idx;
  assign w_wr_data = r_s3_val;
`else
  assign w_wr_vld  = r_s2_vld;
  assign w_wr_end  = r_s2_end;
  assign w_wr_idx  = r_s2_idx;
  assign w_wr_data = 32'(r_s2_mag);
`endif

  always_ff @(posedge pix_clk or posedge rst) begin
    if (rst) begin
      r_state      <= FILL;
      r_hold       <= 1'b0;
      r_idx        <= '0;
      r_valid_flag <= 1'b0;
      r_bank       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        FILL: begin
          if (w_err) begin
            r_idx <= '0;
            r_err <= 1'b1;
          end else if (w_good_end) begin
            r_hold <= 1'b1;
          end else if (w_acc) begin
            r_idx <= r_idx + c_aw'(1);
          end
          if (w_wr_vld && w_wr_end) r_state <= PEND;
        end
        PEND: begin
          // Swap only between display lines so a line never mixes frames
          if (!data_req) begin
            r_bank       <= ~r_bank;
            r_done       <= 1'b1;
            r_valid_flag <= 1'b1;
            r_idx        <= '0;
            r_hold       <= 1'b0;
            r_state      <= FILL;
          end
        end
        default: r_state <= FILL;
      endcase
    end
  end

  assign w_addr_ext = {1'b0, RAM_address};

  always_ff @(posedge pix_clk or posedge rst) begin
    if (rst)           r_rd_zero <= 1'b1;
    else if (data_req) r_rd_zero <= !r_valid_flag || (w_addr_ext >= 11'(FFT_POINT));
  end

  assign fft_data   = r_rd_zero ? 32'd0 : w_rd_data;
  assign frame_done = r_done;
  assign frame_err  = r_err;

  spec_dpram #(
    .DEPTH (FFT_POINT),
    .AW    (c_aw)
  ) u_dpram (
    .pix_clk    (pix_clk),
    .rst        (rst),
    .i_wr_en    (w_wr_vld),
    .i_wr_addr  ({r_bank, w_wr_idx}),
    .i_wr_data  (w_wr_data),
    .i_rd_en    (data_req),
    .i_rd_addr  ({~r_bank, RAM_address[c_aw-1:0]}),
    .o_rd_data  (w_rd_data)
`ifdef FFT_SPEC_AVG_EN
    ,
    .i_old_addr ({~r_bank, r_s1_idx}),
    .o_old_data (w_old)
`endif
  );

endmodule

`default_nettype wire

// File: tb/tb_fft_spec_buf.sv
// ---------------------------------------------------------------------------
// Module  : tb_fft_spec_buf
// Brief   : Directed self-checking bench for fft_spec_buf (256 bins, 16-bit)
// Rev     : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_fft_spec_buf;

  localparam int N = 256;

  logic        pix_clk = 1'b0;
  logic        rst;
  logic [15:0] fft_re, fft_im;
  logic        fft_valid, fft_last, fft_ready, data_req;
  logic [9:0]  RAM_address;
  logic [31:0] fft_data;
  logic        frame_done, frame_err;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  int err_cnt  = 0;

  always #5 pix_clk = ~pix_clk;

  fft_spec_buf #(
    .FFT_POINT (N),
    .DATA_W    (16),
    .MAG_SHIFT (0)
  ) dut (
    .pix_clk     (pix_clk),
    .rst         (rst),
    .fft_re      (fft_re),
    .fft_im      (fft_im),
    .fft_valid   (fft_valid),
    .fft_last    (fft_last),
    .fft_ready   (fft_ready),
    .data_req    (data_req),
    .RAM_address (RAM_address),
    .fft_data    (fft_data),
    .frame_done  (frame_done),
    .frame_err   (frame_err)
  );

  always @(negedge pix_clk) begin
    if (frame_done) done_cnt++;
    if (frame_err)  err_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge pix_clk);
    #1;
  endtask

  // Streams nbins bins; bin sp_idx gets the alternate value, last_at < 0 means no fft_last
  task automatic feed(input int nbins, input int last_at, input logic [15:0] re,
                      input logic [15:0] im, input int sp_idx,
                      input logic [15:0] sp_re, input logic [15:0] sp_im);
    int w;
    for (int i = 0; i < nbins; i++) begin
      w = 0;
      while (!fft_ready && w < 3000) begin
        tick();
        w++;
      end
      if (!fft_ready) check("ready_timeout", 32'(fft_ready), 32'd1);
      fft_valid = 1'b1;
      fft_re    = (i == sp_idx) ? sp_re : re;
      fft_im    = (i == sp_idx) ? sp_im : im;
      fft_last  = (i == last_at);
      tick();
    end
    fft_valid = 1'b0;
    fft_last  = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [9:0] addr, input logic [31:0] exp);
    data_req    = 1'b1;
    RAM_address = addr;
    tick();
    data_req    = 1'b0;
    check(tag, fft_data, exp);
  endtask

  task automatic full_frame(input string tag, input logic [15:0] re, input logic [15:0] im);
    int d0;
    d0 = done_cnt;
    feed(N, N - 1, re, im, -1, 16'd0, 16'd0);
    repeat (10) tick();
    check(tag, 32'(done_cnt - d0), 32'd1);
  endtask

  initial begin
    int d0, e0;
    rst = 1'b1; fft_re = '0; fft_im = '0; fft_valid = 1'b0; fft_last = 1'b0;
    data_req = 1'b0; RAM_address = '0;
    repeat (3) tick();
    check("rst_ready", 32'(fft_ready), 32'd1);
    check("rst_data",  fft_data, 32'd0);
    check("rst_done",  32'(frame_done), 32'd0);
    check("rst_err",   32'(frame_err), 32'd0);
    rst = 1'b0;
    tick();
    rd_check("no_frame_rd", 10'd0, 32'd0);

`ifdef FFT_SPEC_AVG_EN
    full_frame("avg1_done", 16'd100, 16'd0);
    rd_check("avg1_bin3", 10'd3, 32'd25);
    full_frame("avg2_done", 16'd100, 16'd0);
    rd_check("avg2_bin3", 10'd3, 32'd43);
    full_frame("avg3_done", 16'd100, 16'd0);
    rd_check("avg3_bin3", 10'd3, 32'd57);
`else
    // re=3, im=-4 -> 4 + (3>>1) = 5
    e0 = err_cnt;
    full_frame("A_done_once", 16'd3, 16'hFFFC);
    check("A_no_err", 32'(err_cnt - e0), 32'd0);
    rd_check("A_bin0", 10'd0, 32'd5);
    rd_check("A_addr300", 10'd300, 32'd0);
    rd_check("A_bin255", 10'd255, 32'd5);
    repeat (3) tick();
    check("A_hold", fft_data, 32'd5);

    d0 = done_cnt;
    feed(N, N - 1, 16'd3, 16'hFFFC, 7, 16'h8000, 16'd0);
    repeat (10) tick();
    check("B_done", 32'(done_cnt - d0), 32'd1);
    rd_check("B_bin7_minneg", 10'd7, 32'd32768);
    rd_check("B_bin6", 10'd6, 32'd5);
    rd_check("B_addr256", 10'd256, 32'd0);

    // Frame completes while the display keeps reading: swap must wait
    d0 = done_cnt;
    data_req = 1'b1;
    RAM_address = 10'd0;
    feed(N, N - 1, 16'd10, 16'd0, -1, 16'd0, 16'd0);
    repeat (1280 - N) tick();
    check("C_no_swap", 32'(done_cnt - d0), 32'd0);
    check("C_ready_low", 32'(fft_ready), 32'd0);
    check("C_old_frame", fft_data, 32'd5);
    data_req = 1'b0;
    tick();
    check("C_done_pulse", 32'(frame_done), 32'd1);
    tick();
    check("C_done_single", 32'(frame_done), 32'd0);
    check("C_ready_back", 32'(fft_ready), 32'd1);
    rd_check("C_bin0", 10'd0, 32'd10);

    d0 = done_cnt;
    e0 = err_cnt;
    feed(101, 100, 16'd0, 16'd20, -1, 16'd0, 16'd0);
    repeat (5) tick();
    check("E_early_last", 32'(err_cnt - e0), 32'd1);
    check("E_ready", 32'(fft_ready), 32'd1);
    feed(N, -1, 16'd0, 16'd20, -1, 16'd0, 16'd0);
    repeat (5) tick();
    check("E_missing_last", 32'(err_cnt - e0), 32'd2);
    check("E_no_done", 32'(done_cnt - d0), 32'd0);
    rd_check("E_still_old", 10'd0, 32'd10);
    full_frame("E_recover_done", 16'd0, 16'd20);
    rd_check("E_bin0", 10'd0, 32'd20);
    rd_check("E_bin100", 10'd100, 32'd20);
    rd_check("E_bin255", 10'd255, 32'd20);

    full_frame("R_first_done", 16'd9, 16'd0);
    rd_check("R_first_bin0", 10'd0, 32'd9);
    feed(50, -1, 16'd11, 16'd0, -1, 16'd0, 16'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("R_ready", 32'(fft_ready), 32'd1);
    rd_check("R_bin0_cleared", 10'd0, 32'd0);
    rd_check("R_bin49_cleared", 10'd49, 32'd0);
    full_frame("R_new_done", 16'd7, 16'd0);
    rd_check("R_bin5", 10'd5, 32'd7);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
